// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C register target: FSM state encoding,
// ACK/NACK bus levels and default sizing parameters.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_IGNORE   = 4'd3,
    ST_WR_PTR   = 4'd4,
    ST_WR_DATA  = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_RD_DATA  = 4'd7,
    ST_RD_ACK   = 4'd8
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int DEFAULT_ADDR_W     = 4;
  localparam int DEFAULT_FILTER_LEN = 3;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer, glitch filter and edge detector for one I2C line.
// The filtered level only follows the pin after FILTER_LEN consecutive differing samples.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_q;

  // Lines idle high, so reset to 1 to avoid a spurious edge when reset releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= 2'b11;
      cnt     <= '0;
      level   <= 1'b1;
      level_q <= 1'b1;
    end else begin
      sync    <= {sync[0], raw};
      level_q <= level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C target with a 2^ADDR_W x 8 register file shared with an Avalon-MM slave port.
// Optional irq output (set on I2C write commit, cleared by Avalon read) under I2C_REG_SLAVE_IRQ_EN.
module i2c_reg_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         ADDR_W     = DEFAULT_ADDR_W,
  parameter int         FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [7:0]        writedata,
  output logic [7:0]        readdata,
  output logic              busy,
`ifdef I2C_REG_SLAVE_IRQ_EN
  output logic              irq,
`endif
  output logic [3:0]        state_dbg
);

  localparam int NREG = 1 << ADDR_W;

  i2c_state_e        state, state_next;
  logic              scl, scl_rise, scl_fall;
  logic              sda, sda_rise, sda_fall;
  logic              start_cond, stop_cond;
  logic [7:0]        shreg;
  logic [2:0]        bitcnt;
  logic              byte_full;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        regs [NREG];
  logic [7:0]        rd_byte;
  logic              addr_match;
  logic              av_we;

  logic sda_oe_next, shift_in, shift_out, clr_bits;
  logic ld_ptr, inc_ptr, i2c_we, ld_rd;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk   (clk),
    .reset (reset),
    .raw   (scl_in),
    .level (scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk   (clk),
    .reset (reset),
    .raw   (sda_in),
    .level (sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  assign start_cond = sda_fall & scl;
  assign stop_cond  = sda_rise & scl;
  assign addr_match = (shreg[7:1] == SLAVE_ADDR);
  assign rd_byte    = regs[ptr];

  // Avalon handshake: no waitrequest. A write is taken on the clk edge where
  // chipselect & ~write_n; readdata is valid combinationally in the same cycle.
  assign av_we     = chipselect & ~write_n;
  assign readdata  = regs[address];
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start_cond) begin
      state_next = ST_ADDR;
    end else if (stop_cond) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_ADDR:     if (scl_fall && byte_full) state_next = addr_match ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK: if (scl_fall) state_next = shreg[0] ? ST_RD_DATA : ST_WR_PTR;
        ST_WR_PTR:   if (scl_fall && byte_full) state_next = ST_WR_ACK;
        ST_WR_DATA:  if (scl_fall && byte_full) state_next = ST_WR_ACK;
        ST_WR_ACK:   if (scl_fall) state_next = ST_WR_DATA;
        ST_RD_DATA:  if (scl_fall && bitcnt == 3'd7) state_next = ST_RD_ACK;
        ST_RD_ACK: begin
          if (scl_rise && sda == I2C_NACK) state_next = ST_IGNORE;
          else if (scl_fall)               state_next = ST_RD_DATA;
        end
        default: state_next = state;
      endcase
    end
  end

  // SDA drive only changes on a filtered SCL fall, so it is never altered while SCL is high.
  always_comb begin
    sda_oe_next = sda_oe;
    shift_in    = 1'b0;
    shift_out   = 1'b0;
    clr_bits    = 1'b0;
    ld_ptr      = 1'b0;
    inc_ptr     = 1'b0;
    i2c_we      = 1'b0;
    ld_rd       = 1'b0;
    if (start_cond || stop_cond) begin
      sda_oe_next = 1'b0;
      clr_bits    = 1'b1;
    end else begin
      case (state)
        ST_ADDR, ST_WR_PTR, ST_WR_DATA: begin
          shift_in = scl_rise;
          if (scl_fall && byte_full) begin
            clr_bits    = 1'b1;
            sda_oe_next = (state != ST_ADDR) || addr_match;
            ld_ptr      = (state == ST_WR_PTR);
            i2c_we      = (state == ST_WR_DATA);
            inc_ptr     = (state == ST_WR_DATA);
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin
          clr_bits    = 1'b1;
          ld_rd       = shreg[0];
          sda_oe_next = shreg[0] & ~rd_byte[7];
        end
        ST_WR_ACK: if (scl_fall) begin
          clr_bits    = 1'b1;
          sda_oe_next = 1'b0;
        end
        ST_RD_DATA: if (scl_fall) begin
          if (bitcnt == 3'd7) begin
            clr_bits    = 1'b1;
            sda_oe_next = 1'b0;
          end else begin
            shift_out   = 1'b1;
            sda_oe_next = ~shreg[6];
          end
        end
        ST_RD_ACK: begin
          inc_ptr = scl_rise && (sda == I2C_ACK);
          if (scl_fall) begin
            clr_bits    = 1'b1;
            ld_rd       = 1'b1;
            sda_oe_next = ~rd_byte[7];
          end
        end
        default: sda_oe_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sda_oe    <= 1'b0;
      shreg     <= '0;
      bitcnt    <= '0;
      byte_full <= 1'b0;
      ptr       <= '0;
    end else begin
      sda_oe <= sda_oe_next;
      if (ld_rd)          shreg <= rd_byte;
      else if (shift_in)  shreg <= {shreg[6:0], sda};
      else if (shift_out) shreg <= {shreg[6:0], 1'b0};
      if (clr_bits) begin
        bitcnt    <= '0;
        byte_full <= 1'b0;
      end else if (shift_in || shift_out) begin
        bitcnt <= bitcnt + 3'd1;
        if (shift_in && bitcnt == 3'd7) byte_full <= 1'b1;
      end
      if (ld_ptr)       ptr <= shreg[ADDR_W-1:0];
      else if (inc_ptr) ptr <= ptr + ADDR_W'(1);
    end
  end

  // I2C commit takes priority when both ports hit the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i2c_we && ptr == ADDR_W'(i))        regs[i] <= shreg;
        else if (av_we && address == ADDR_W'(i)) regs[i] <= writedata;
      end
    end
  end

`ifdef I2C_REG_SLAVE_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset)                       irq <= 1'b0;
    else if (i2c_we)                 irq <= 1'b1;
    else if (chipselect && write_n)  irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged I2C master, Avalon driver, and a
// transaction-level register/pointer model with randomized traffic.
module tb_i2c_reg_slave;
  import i2c_pkg::*;

  localparam logic [6:0] SLAVE = 7'h50;
  localparam int         Q     = 8;

  logic       clk = 1'b0;
  logic       reset, scl_in, sda_m, sda_in, sda_oe;
  logic [3:0] address;
  logic       chipselect, write_n;
  logic [7:0] writedata, readdata;
  logic       busy;
  logic [3:0] state_dbg;
`ifdef I2C_REG_SLAVE_IRQ_EN
  logic       irq;
`endif

  // Open-drain bus: either side can pull low.
  assign sda_in = sda_m & ~sda_oe;

  i2c_reg_slave dut (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .busy       (busy),
`ifdef I2C_REG_SLAVE_IRQ_EN
    .irq        (irq),
`endif
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] mem [16];
  int         m_ptr;
  logic [7:0] exp_q [$];
  logic [7:0] wr_q  [$];
  bit         glitch_en, mon_en, xfer_done;
  logic       rst_edge, oe_prev;
  int         oe_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Bus monitor: the target may only change its SDA drive while SCL is low.
  always @(posedge clk) rst_edge <= reset;
  always @(negedge clk) begin
    if (sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
    if (mon_en && sda_oe !== oe_prev && !rst_edge) check("oe_scl_low", {31'd0, scl_in}, 32'd0);
    oe_prev <= sda_oe;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got=timeout want=finish");
    bad++;
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_tx(input logic b, output logic r);
    sda_m = b;
    tick(Q);
    scl_in = 1'b1;
    tick(Q / 2);
    if (glitch_en) begin
      sda_m = ~sda_m;
      tick(1);
      sda_m = ~sda_m;
      tick(Q / 2 - 1);
    end else begin
      tick(Q / 2);
    end
    r = sda_in;
    tick(Q);
    scl_in = 1'b0;
    tick(Q);
  endtask

  task automatic send_start();
    sda_m = 1'b1;
    tick(Q);
    scl_in = 1'b1;
    tick(Q);
    sda_m = 1'b0;
    tick(Q);
    scl_in = 1'b0;
    tick(Q);
  endtask

  task automatic send_stop();
    sda_m = 1'b0;
    tick(Q);
    scl_in = 1'b1;
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_n);
    logic r;
    for (int i = 7; i >= 0; i--) bit_tx(b[i], r);
    bit_tx(1'b1, ack_n);
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_tx(1'b1, r);
      d[i] = r;
    end
    bit_tx(ack_bit, r);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] p, input int n);
    logic       ack_n, hit;
    logic [7:0] d;
    hit = (a == SLAVE);
    send_start();
    send_byte({a, 1'b0}, ack_n);
    check("wr_addr_ack", ack_n, !hit);
    send_byte(p, ack_n);
    check("wr_ptr_ack", ack_n, !hit);
    if (hit) m_ptr = int'(p[3:0]);
    for (int i = 0; i < n; i++) begin
      d = wr_q.pop_front();
      send_byte(d, ack_n);
      check("wr_data_ack", ack_n, !hit);
      if (hit) begin
        mem[m_ptr] = d;
        m_ptr = (m_ptr + 1) % 16;
      end
    end
  endtask

  task automatic do_read(input logic [6:0] a, input int n);
    logic       ack_n, hit;
    logic [7:0] d;
    hit = (a == SLAVE);
    send_start();
    send_byte({a, 1'b1}, ack_n);
    check("rd_addr_ack", ack_n, !hit);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(hit ? mem[m_ptr] : 8'hFF);
      recv_byte(i == n - 1, d);
      check("rd_data", d, exp_q.pop_front());
      if (hit && i != n - 1) m_ptr = (m_ptr + 1) % 16;
    end
  endtask

  task automatic stop_and_idle();
    send_stop();
    tick(16);
    check("busy_idle", busy, 1'b0);
  endtask

  task automatic av_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic av_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic check_regs();
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      av_read(4'(i), d);
      check($sformatf("reg%0d", i), d, mem[i]);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       ack_n;
    int         c0, op, n;
    logic [6:0] a;
    logic [3:0] ai;

    reset = 1'b1; scl_in = 1'b1; sda_m = 1'b1;
    chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    glitch_en = 1'b0; mon_en = 1'b0; xfer_done = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    m_ptr = 0;
    tick(4);
    reset = 1'b0;
    tick(2);
    mon_en = 1'b1;
    check("rst_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_rd", readdata, 8'h00);

    // Basic write of two bytes from pointer 3.
    wr_q = '{8'h11, 8'h22};
    do_write(SLAVE, 8'h03, 2);
    stop_and_idle();
    av_read(4'd3, d); check("reg3", d, 8'h11);
    av_read(4'd4, d); check("reg4", d, 8'h22);

    // Pointer wrap from 15 to 0.
    wr_q = '{8'hAA, 8'hBB};
    do_write(SLAVE, 8'h0F, 2);
    stop_and_idle();
    av_read(4'd15, d); check("reg15", d, 8'hAA);
    av_read(4'd0, d);  check("reg0_wrap", d, 8'hBB);

    // Avalon write, then pointer set + repeated START read of two bytes.
    av_write(4'd5, 8'h5C); mem[5] = 8'h5C;
    do_write(SLAVE, 8'h05, 0);
    do_read(SLAVE, 2);
    check("nack_release", sda_oe, 1'b0);
    stop_and_idle();

    // Wrong address: never drives SDA, registers untouched.
    c0 = oe_cnt;
    wr_q = '{8'h66};
    do_write(7'h51, 8'h02, 1);
    stop_and_idle();
    check("nomatch_oe", oe_cnt - c0, 0);
    check_regs();

    // One-cycle SDA glitches while SCL is high must not break the transfer.
    glitch_en = 1'b1;
    wr_q = '{8'hC3, 8'h5A};
    do_write(SLAVE, 8'h09, 2);
    glitch_en = 1'b0;
    stop_and_idle();
    av_read(4'd9, d);  check("glitch_reg9", d, 8'hC3);
    av_read(4'd10, d); check("glitch_reg10", d, 8'h5A);

    // Avalon write to another register held across an I2C commit: both land.
    xfer_done = 1'b0;
    fork
      begin
        wr_q = '{8'h3D};
        do_write(SLAVE, 8'h08, 1);
        xfer_done = 1'b1;
      end
      begin
        tick(40);
        address = 4'd12; writedata = 8'h77; chipselect = 1'b1; write_n = 1'b0;
        wait (xfer_done);
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
      end
    join
    mem[12] = 8'h77;
    stop_and_idle();
    av_read(4'd8, d);  check("both_reg8", d, 8'h3D);
    av_read(4'd12, d); check("both_reg12", d, 8'h77);

    // Randomized mix of I2C writes, reads and Avalon writes.
    for (int it = 0; it < 14; it++) begin
      op = $urandom_range(0, 3);
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLAVE;
      n  = $urandom_range(1, 3);
      if (op <= 1) begin
        wr_q.delete();
        for (int k = 0; k < n; k++) wr_q.push_back(8'($urandom));
        do_write(a, 8'($urandom), n);
        stop_and_idle();
      end else if (op == 2) begin
        do_read(a, n);
        stop_and_idle();
      end else begin
        ai = 4'($urandom_range(0, 15));
        d  = 8'($urandom);
        av_write(ai, d);
        mem[ai] = d;
      end
    end
    check_regs();

    // Reset in the middle of a read while the target pulls SDA low.
    av_write(4'(m_ptr), 8'h00);
    mem[m_ptr] = 8'h00;
    send_start();
    send_byte({SLAVE, 1'b1}, ack_n);
    check("rst_rd_ack", ack_n, 1'b0);
    sda_m = 1'b1;
    tick(Q);
    scl_in = 1'b1;
    tick(2);
    check("rd_drive", sda_oe, 1'b1);
    reset = 1'b1;
    tick(1);
    check("rst_mid_oe", sda_oe, 1'b0);
    reset = 1'b0;
    tick(10);
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    m_ptr = 0;
    check("rst_mid_busy", busy, 1'b0);
    check_regs();
    wr_q = '{8'h99};
    do_write(SLAVE, 8'h07, 1);
    stop_and_idle();
    av_read(4'd7, d); check("post_rst_reg7", d, 8'h99);
    do_read(SLAVE, 1);
    stop_and_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
